counter_universal: RTL and testbench

Parametrised up/down counter with programmable modulus, variable step, wrap or saturate mode, synchronous load, a cascade carry and a sticky overflow flag. It generalises the team's existing behavioural, JK and T flip-flop counters, whose ranges are fixed at 2**n and whose step is fixed at 1. It is the standard counting primitive for timers, dividers and address generators, and instances can be chained through `carry` into a downstream stage's `en`.

---
 rtl/counter_universal.sv | 129 ++++++++++++
 tb/tb_counter_universal.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_universal.sv
// -----------------------------------------------------------------------------
// counter_universal
//
// Parametrised up/down counter with a programmable modulus, variable step,
// wrap or saturate behaviour, synchronous load, a combinational cascade carry
// and a sticky overflow flag.
//
// Parameters
//   n        counter width in bits (n >= 2)
//   MODULUS  count range is 0..MODULUS-1, 2 <= MODULUS <= 2**n
//
// Ports
//   clk       in   rising-edge clock
//   res_n     in   asynchronous active-low reset
//   en        in   count enable
//   count_up  in   1 = increment, 0 = decrement
//   load      in   synchronous load of set (wins over en)
//   set       in   load value, clamped to MODULUS-1
//   step      in   step magnitude, clamped to MODULUS-1; 0 = hold
//   sat       in   1 = saturate at the bounds, 0 = wrap modulo MODULUS
//   clr_ovf   in   synchronous clear of ovf (an event in the same cycle wins)
//   count     out  registered count
//   carry     out  combinational: the next edge is a boundary event
//   ovf       out  registered sticky boundary-event flag
// -----------------------------------------------------------------------------
module counter_universal #(
  parameter int n       = 4,
  parameter int MODULUS = 2 ** n
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  input  logic         count_up,
  input  logic         load,
  input  logic [n-1:0] set,
  input  logic [n-1:0] step,
  input  logic         sat,
  input  logic         clr_ovf,
  output logic [n-1:0] count,
  output logic         carry,
  output logic         ovf
);

  // All arithmetic is carried out on n+1 bits so that count+step and
  // count+MODULUS-step never truncate, even when MODULUS == 2**n.
  localparam int         MAX_I = MODULUS - 1;
  localparam logic [n:0] MOD_W = MODULUS[n:0];
  localparam logic [n:0] MAX_W = MAX_I[n:0];

  logic [n-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  logic [n:0]   count_ext;
  logic [n:0]   step_ext;
  logic [n:0]   set_ext;
  logic [n:0]   step_eff;
  logic [n:0]   set_eff;
  logic [n:0]   sum_up;
  logic [n:0]   step_next;
  logic         out_of_range;
  logic         boundary_event;

  always_comb begin
    count_ext = {1'b0, count_q};
    step_ext  = {1'b0, step};
    set_ext   = {1'b0, set};

    // Oversized step / load values are clamped to the top of the range.
    step_eff  = (step_ext > MAX_W) ? MAX_W : step_ext;
    set_eff   = (set_ext  > MAX_W) ? MAX_W : set_ext;

    sum_up       = count_ext + step_eff;
    out_of_range = 1'b0;
    step_next    = count_ext;

    if (count_up) begin
      if (sum_up <= MAX_W) begin
        step_next = sum_up;
      end else begin
        out_of_range = 1'b1;
        step_next    = sat ? MAX_W : (sum_up - MOD_W);
      end
    end else begin
      if (step_eff <= count_ext) begin
        step_next = count_ext - step_eff;
      end else begin
        out_of_range = 1'b1;
        // count < step here, so count+MODULUS-step stays below MODULUS.
        step_next    = sat ? '0 : (count_ext + MOD_W - step_eff);
      end
    end

    // A zero step is always in range, so it never raises an event. Sitting
    // at a saturation bound with a nonzero step is an event on every edge.
    boundary_event = en && !load && out_of_range;

    count_d = count_q;
    if (load) begin
      count_d = set_eff[n-1:0];
    end else if (en) begin
      count_d = step_next[n-1:0];
    end

    // Set has priority over clear so a simultaneous event is never lost.
    ovf_d = ovf_q;
    if (boundary_event) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  // Gated with reset so a downstream stage never sees a spurious enable
  // while this stage is held in reset (count=0 counting down would else fire).
  assign carry = boundary_event && res_n;

endmodule

// File: tb/tb_counter_universal.sv
// -----------------------------------------------------------------------------
// tb_counter_universal
//
// Drives two counter_universal instances from the same inputs: one with
// n=4/MODULUS=10 and one with n=4/MODULUS=16. Each is compared every cycle
// against an integer reference model of the counting rules. Directed
// scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_counter_universal;

  logic       clk;
  logic       res_n;
  logic       en;
  logic       count_up;
  logic       load;
  logic [3:0] set;
  logic [3:0] step;
  logic       sat;
  logic       clr_ovf;

  logic [3:0] count_a, count_b;
  logic       carry_a, carry_b;
  logic       ovf_a, ovf_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: index 0 = MODULUS 10, index 1 = MODULUS 16.
  int m_mod [2] = '{10, 16};
  int m_cnt [2];
  bit m_ovf [2];
  int cyc_no = 0;

  counter_universal #(.n(4), .MODULUS(10)) dut_a (
    .clk     (clk),
    .res_n   (res_n),
    .en      (en),
    .count_up(count_up),
    .load    (load),
    .set     (set),
    .step    (step),
    .sat     (sat),
    .clr_ovf (clr_ovf),
    .count   (count_a),
    .carry   (carry_a),
    .ovf     (ovf_a)
  );

  counter_universal #(.n(4), .MODULUS(16)) dut_b (
    .clk     (clk),
    .res_n   (res_n),
    .en      (en),
    .count_up(count_up),
    .load    (load),
    .set     (set),
    .step    (step),
    .sat     (sat),
    .clr_ovf (clr_ovf),
    .count   (count_b),
    .carry   (carry_b),
    .ovf     (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Next value of an enabled count, and whether that move leaves the range.
  function automatic void model_next(input int c, input int m, input bit up,
                                     input int stp, input bit sa,
                                     output int nx, output bit oor);
    int s;
    int t;
    s = (stp > m - 1) ? m - 1 : stp;
    if (up) begin
      t = c + s;
      oor = (t >= m);
      nx  = !oor ? t : (sa ? m - 1 : t % m);
    end else begin
      t = c - s;
      oor = (t < 0);
      nx  = !oor ? t : (sa ? 0 : t + m);
    end
  endfunction

  function automatic int dut_count(input int k);
    return (k == 0) ? int'(count_a) : int'(count_b);
  endfunction
  function automatic int dut_carry(input int k);
    return (k == 0) ? int'(carry_a) : int'(carry_b);
  endfunction
  function automatic int dut_ovf(input int k);
    return (k == 0) ? int'(ovf_a) : int'(ovf_b);
  endfunction

  // One clock cycle: apply inputs away from the edge, check carry, clock,
  // then check count and ovf on the falling edge.
  task automatic cyc(input bit e, input bit u, input bit ld, input int st,
                     input int stp, input bit sa, input bit cl);
    int nx [2];
    bit oor [2];
    bit ev [2];
    en = e; count_up = u; load = ld; set = st[3:0]; step = stp[3:0];
    sat = sa; clr_ovf = cl;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_next(m_cnt[k], m_mod[k], u, stp, sa, nx[k], oor[k]);
      ev[k] = e && !ld && oor[k];
      chk($sformatf("carry_m%0d", m_mod[k]), dut_carry(k), int'(ev[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ld) m_cnt[k] = (st > m_mod[k] - 1) ? m_mod[k] - 1 : st;
      else if (e) m_cnt[k] = nx[k];
      if (ev[k]) m_ovf[k] = 1'b1;
      else if (cl) m_ovf[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count_m%0d", m_mod[k]), dut_count(k), m_cnt[k]);
      chk($sformatf("ovf_m%0d", m_mod[k]), dut_ovf(k), int'(m_ovf[k]));
    end
    cyc_no++;
    $display("cyc %0d en=%0b up=%0b ld=%0b set=%0d step=%0d sat=%0b clr=%0b | m10 cnt=%0d ovf=%0b | m16 cnt=%0d ovf=%0b",
             cyc_no, e, u, ld, st, stp, sa, cl, count_a, ovf_a, count_b, ovf_b);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  initial begin
    res_n = 1'b0; en = 1'b1; count_up = 1'b0; load = 1'b0; set = '0;
    step = 4'd1; sat = 1'b0; clr_ovf = 1'b0;
    model_reset();

    // Reset state; count=0 counting down would be an event without reset.
    repeat (2) @(negedge clk);
    chk("rst_count_m10", int'(count_a), 0);
    chk("rst_ovf_m10",   int'(ovf_a),   0);
    chk("rst_carry_m10", int'(carry_a), 0);
    chk("rst_count_m16", int'(count_b), 0);
    chk("rst_carry_m16", int'(carry_b), 0);
    res_n = 1'b1;
    #1;

    // Up wrap, step 1: m10 wraps after 10 edges, m16 after 16.
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 1, 0, 0);
    chk("upwrap_count_m10", int'(count_a), 0);
    chk("upwrap_ovf_m10",   int'(ovf_a),   1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 1, 0, 0);
    chk("upwrap_count_m16", int'(count_b), 0);
    chk("upwrap_ovf_m16",   int'(ovf_b),   1);

    // Down wrap, step 3, from 2: 9, 6, 3, 0, 7.
    cyc(0, 0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 3, 0, 0);
    chk("downwrap_count_m10", int'(count_a), 7);

    // Saturate up step 4 from 7, then down step 4 from 1.
    cyc(0, 1, 1, 7, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 4, 1, 0);
    chk("satup_count_m10", int'(count_a), 9);
    cyc(0, 0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 4, 1, 0);
    chk("satdn_count_m10", int'(count_a), 0);

    // Step 15 clamps to 9 in the MODULUS=10 instance.
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 15, 1, 0);
    chk("clamp_count_m10", int'(count_a), 9);

    // Load clamp with en=0, then load overriding an enabled step.
    cyc(0, 1, 1, 13, 0, 0, 0);
    chk("ldclamp_count_m10", int'(count_a), 9);
    cyc(1, 1, 1, 5, 3, 0, 0);
    chk("ldpri_count_m10", int'(count_a), 5);

    // Hold for 16 cycles with other inputs wiggling.
    for (int i = 0; i < 16; i++)
      cyc(0, 1'($urandom), 0, int'($urandom_range(15)), int'($urandom_range(15)),
          1'($urandom), 0);

    // Clear without event, then clear colliding with a 9->0 wrap.
    cyc(0, 1, 0, 0, 1, 0, 1);
    chk("clr_ovf_m10", int'(ovf_a), 0);
    cyc(0, 1, 1, 9, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 1);
    chk("clrwrap_ovf_m10", int'(ovf_a), 1);

    // Async reset between edges from count=7, ovf=1.
    cyc(0, 1, 1, 7, 0, 0, 0);
    #2;
    res_n = 1'b0;
    #1;
    chk("async_count_m10", int'(count_a), 0);
    chk("async_ovf_m10",   int'(ovf_a),   0);
    chk("async_carry_m10", int'(carry_a), 0);
    chk("async_count_m16", int'(count_b), 0);
    res_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Randomized run.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(9) < 7), 1'($urandom), ($urandom_range(9) == 0),
          int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom),
          ($urandom_range(5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
